// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the VGA sync generator to the character generator,
// the graphics stages and the connector.
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
    logic       blink;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on,
        output hsync, vsync, frame_tick, blink
    );

    modport slave (
        input p_tick, pixel_x, pixel_y, video_on,
        input hsync, vsync, frame_tick, blink
    );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing from the system clock: pixel enable, coordinates,
// registered active-low syncs, a frame tick and a slow cursor blink.
module vga_sync_gen #(
    parameter int DIV          = 4,
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int BLINK_FRAMES = 30
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [9:0]         pixel_x;
    logic [9:0]         pixel_y;
    logic [9:0]         x_next;
    logic [9:0]         y_next;
    logic               hsync_q;
    logic               vsync_q;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_q;
    logic               p_tick;
    logic               frame_tick;

    assign p_tick     = (div_cnt == DIV_LAST);
    assign frame_tick = p_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);

    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (p_tick) begin
            if (pixel_x == H_LAST) begin
                x_next = '0;
                y_next = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
            end else begin
                x_next = pixel_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Syncs are decoded from the next-state counters so they flip on the
    // same edge as the coordinates instead of one clock later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_x <= '0;
            pixel_y <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            pixel_x <= x_next;
            pixel_y <= y_next;
            hsync_q <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync_q <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign vga.p_tick     = p_tick;
    assign vga.pixel_x    = pixel_x;
    assign vga.pixel_y    = pixel_y;
    assign vga.video_on   = (pixel_x < H_VIS) && (pixel_y < V_VIS);
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.frame_tick = frame_tick;
    assign vga.blink      = blink_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster: every clock is compared with
// an arithmetic model driven by the number of edges since reset release.
module tb_vga_sync_gen;
    localparam int DIV = 3;
    localparam int HD = 16, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6,  VF = 1, VS = 2, VB = 1;
    localparam int BF = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT * DIV;

    logic clk;
    logic reset;
    int   tests;
    int   failed;
    int   n;
    int   last_pt;

    vga_sync_gen_if vif ();

    vga_sync_gen #(
        .DIV(DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vga  (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    // Output state after k edges since release: pixel index = k/DIV, then
    // plain division into column, row, frame and blink half-period.
    function automatic logic [25:0] model(input int k);
        int p, x, y, f;
        logic pt, von, hs, vs, ft, bl;
        p   = k / DIV;
        x   = p % HT;
        y   = (p / HT) % VT;
        f   = p / (HT * VT);
        pt  = (k % DIV) == DIV - 1;
        von = (x < HD) && (y < VD);
        hs  = !((x >= HD + HF) && (x < HD + HF + HS));
        vs  = !((y >= VD + VF) && (y < VD + VF + VS));
        ft  = pt && (x == HT - 1) && (y == VT - 1);
        bl  = ((f / BF) % 2) == 1;
        return {pt, 10'(x), 10'(y), von, hs, vs, ft, bl};
    endfunction

    function automatic logic [25:0] observed();
        return {vif.p_tick, vif.pixel_x, vif.pixel_y, vif.video_on,
                vif.hsync, vif.vsync, vif.frame_tick, vif.blink};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) n++;
        @(negedge clk);
        chk("outs", 32'(observed()), 32'(model(n)));
        if (vif.p_tick) begin
            if (last_pt >= 0) chk("pt_gap", 32'(n - last_pt), 32'(DIV));
            last_pt = n;
        end
    endtask

    // Called at a negedge: asserts reset, checks the asynchronous clear at once.
    task automatic pulse_reset(input int len);
        reset = 1'b1;
        #1;
        n       = 0;
        last_pt = -1;
        chk("async_rst", 32'(observed()), 32'(model(0)));
        chk("rst_ft", 32'(vif.frame_tick), 32'(0));
        repeat (len) step();
        reset = 1'b0;
    endtask

    initial begin
        int ft_seen, up_n, down_n, len;
        logic prev_bl;
        tests   = 0;
        failed  = 0;
        n       = 0;
        last_pt = -1;
        reset   = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        repeat (5) step();
        chk("rst_px", 32'(vif.pixel_x), 32'(0));
        chk("rst_py", 32'(vif.pixel_y), 32'(0));
        chk("rst_hs", 32'(vif.hsync), 32'(1));
        chk("rst_vs", 32'(vif.vsync), 32'(1));
        chk("rst_bl", 32'(vif.blink), 32'(0));
        chk("rst_von", 32'(vif.video_on), 32'(1));
        reset = 1'b0;

        for (int s = 0; s < 4; s++) begin
            len = $urandom_range(2 * FRAME, 50);
            repeat (len) step();
            pulse_reset($urandom_range(3, 1));
        end

        // Land mid-frame with blink high, then reset for a single clock.
        repeat (BF * FRAME + ((VT / 2) * HT + HT - 4) * DIV + 1) step();
        chk("blink_pre", 32'(vif.blink), 32'(1));
        pulse_reset(1);

        ft_seen = 0;
        up_n    = -1;
        down_n  = -1;
        prev_bl = vif.blink;
        for (int i = 0; i < 2 * BF * FRAME + FRAME / 2; i++) begin
            step();
            if (vif.frame_tick) ft_seen++;
            if (!prev_bl && vif.blink && up_n < 0) up_n = n;
            if (prev_bl && !vif.blink && down_n < 0) down_n = n;
            prev_bl = vif.blink;
        end
        chk("ft_count", 32'(ft_seen), 32'((n + 1) / FRAME));
        chk("blink_up", 32'(up_n), 32'(BF * FRAME));
        chk("blink_down", 32'(down_n), 32'(2 * BF * FRAME));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock.
- Outputs the `pixel_x`/`pixel_y` coordinates and the `video_on` flag consumed by `generador_caracteres` and the background/box graphics stage. The same outputs drive `hsync`/`vsync` to the connector.
- Also produces a per-frame tick and a slow `blink` square wave, used to flash the configuration-mode cursor.
- Sits directly upstream of the character generator; all RGB stages are timed against its outputs.

## Interface

Parameters:
- `DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate).
- `H_DISPLAY`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal timing, in pixels.
- `V_DISPLAY`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical timing, in lines.
- `BLINK_FRAMES`, 30: frames per `blink` half-period.

Ports:
- `clk`  in  1  system clock, 100 MHz; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `p_tick`  out  1  one-`clk` pulse, once every `DIV` clocks; pixel enable.
- `pixel_x`  out  10  horizontal count, 0..799.
- `pixel_y`  out  10  vertical count, 0..524.
- `video_on`  out  1  high when `pixel_x<640 && pixel_y<480`.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `frame_tick`  out  1  one-`clk` pulse at the last pixel of each frame.
- `blink`  out  1  square wave, toggles every `BLINK_FRAMES` frames.

## Operation

Clock divider:
- `div_cnt` is a mod-`DIV` counter that advances every `clk`.
- `p_tick = (div_cnt == DIV-1)`.

Horizontal counter:
- Mod-800 (H_TOTAL = 640+16+96+48).
- Advances only on `clk` edges where `p_tick == 1`.
- Wraps 799 -> 0.

Vertical counter:
- Mod-525 (V_TOTAL = 480+10+2+33).
- Advances only on a `p_tick` edge where `pixel_x == 799`.
- Wraps 524 -> 0 on that same edge when `pixel_y == 524`.

Derived outputs:
- `pixel_x`/`pixel_y` are the counter registers themselves; no extra pipeline.
- `hsync` is low exactly while `pixel_x` is in 656..751 (H_DISPLAY+H_FRONT to +H_SYNC-1); otherwise high.
- `vsync` is low exactly while `pixel_y` is in 490..491; otherwise high.
- `hsync`/`vsync` are registered and updated from the next-state counter values, so they change on the same edge as `pixel_x`/`pixel_y` and are glitch-free.
- `video_on` is decoded from the counter registers.

Frame tick:
- `frame_tick` is high during the single `clk` cycle where `p_tick==1 && pixel_x==799 && pixel_y==524`.

Blink:
- `blink_cnt` is a mod-`BLINK_FRAMES` counter, incremented on `frame_tick`.
- When `blink_cnt == BLINK_FRAMES-1` and `frame_tick` is high, `blink_cnt` clears and `blink` inverts.
- Result: 60 frames per full blink period, i.e. 1 Hz at default parameters.

Width rules:
- All comparisons are on 10-bit unsigned values; no signed arithmetic.
- `blink_cnt` width is `$clog2(BLINK_FRAMES)`, minimum 1.

## Timing

Reset values (asynchronous, take effect immediately while `reset` is high):
- `div_cnt=0`, `pixel_x=0`, `pixel_y=0`, `blink_cnt=0`.
- `hsync=1`, `vsync=1`, `blink=0`.
- Therefore `video_on=1`, `p_tick=0`, `frame_tick=0`.

After reset release (first rising edge = edge 1):
- `p_tick` is first high in the cycle after edge 3.
- `pixel_x` becomes 1 at edge 4.

Line and frame periods:
- Line = 800 × 4 = 3200 clk.
- Frame = 525 × 3200 = 1,680,000 clk.

Per-cycle behaviour:
- `frame_tick` and `p_tick` coincide; `pixel_x`/`pixel_y` read 0/0 on the following cycle.
- Between pixel ticks (`p_tick==0`), every output except `p_tick` holds its value.

Boundary conditions:
- `pixel_x` 799 -> 0 and `pixel_y` 524 -> 0 on the same edge.
- `hsync` edges land on the `pixel_x` 655->656 and 751->752 transitions.
- `vsync` edges land on the `pixel_y` 489->490 and 491->492 transitions.
- `reset` asserted mid-line or mid-frame: all state returns to reset values immediately (asynchronous). No partial pulse is held on `frame_tick`.

## Test plan

- **Reset:** assert `reset` for 5 clk, then release. Required: `pixel_x=0`, `pixel_y=0`, `hsync=1`, `vsync=1`, `blink=0`. First `p_tick` appears on the 4th clk after release. `p_tick` period is exactly 4 clk thereafter.
- **Horizontal timing:** run one line. Required: `pixel_x` sequence 0..799 then 0. `hsync` low for exactly 96 ticks (384 clk), starting at `pixel_x=656`. `video_on` falls at `pixel_x=640`. Line length = 3200 clk.
- **Vertical timing:** run one frame. Required: `pixel_y` steps only at `pixel_x` 799->0. `vsync` low for `pixel_y` 490..491 (6400 clk). `video_on` stays 0 for `pixel_y>=480`. `frame_tick` occurs once, 1,680,000 clk after the previous one.
- **Blink:** run 61 frames. Required: `blink` toggles 0->1 at the 30th `frame_tick` and 1->0 at the 60th. Counting `frame_tick` pulses shows no drift.
- **Mid-frame reset:** pulse `reset` for 1 clk at `pixel_x=700`, `pixel_y=300`, with `blink=1`. Required: outputs return to reset values within the same cycle. Counting restarts from 0/0. `blink=0` and the next toggle comes 30 frames later.
- **Sync/coordinate alignment:** over a full frame, check every `clk`. Required: `hsync==!(pixel_x>=656 && pixel_x<=751)` and `vsync==!(pixel_y>=490 && pixel_y<=491)` hold with zero cycle offset.
